// File: rtl/fp32_to_int_pkg.sv
// Shared FP32 definitions: field widths, exponent codes, integer limits and the
// converter state encoding. Intended for reuse by the adder and later FP blocks.
package fp32_to_int_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  localparam logic [FP_EXP_W-1:0] EXP_SPECIAL = 8'hFF;
  localparam logic [FP_EXP_W-1:0] EXP_ZERO    = 8'h00;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    NEG   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp32_to_int_if.sv
// Request/response bundle for the FP32-to-integer converter.
interface fp32_to_int_if;
  logic        start;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  modport master (output start, a, input busy, done, result, err);
  modport slave  (input start, a, output busy, done, result, err);
endinterface

// File: rtl/fp32_classify.sv
// Combinational FP32 field decoder: special-value flags, unbiased exponent and
// the mantissa with its hidden bit restored.
module fp32_classify
  import fp32_to_int_pkg::*;
(
  input  logic              [31:0]        a_i,
  output logic                            is_nan_o,
  output logic                            is_inf_o,
  output logic                            is_zero_o,
  output logic signed       [FP_EXP_W:0]  exp_unb_o,
  output logic              [FP_MANT_W:0] mant_o
);

  logic [FP_EXP_W-1:0]  exp_f;
  logic [FP_MANT_W-1:0] man_f;

  assign exp_f = a_i[30:23];
  assign man_f = a_i[22:0];

  assign is_nan_o  = (exp_f == EXP_SPECIAL) && (man_f != '0);
  assign is_inf_o  = (exp_f == EXP_SPECIAL) && (man_f == '0);
  // Denormals are reported as zero: they truncate to 0 in every integer use.
  assign is_zero_o = (exp_f == EXP_ZERO);
  assign exp_unb_o = $signed({1'b0, exp_f}) - $signed((FP_EXP_W+1)'(FP_BIAS));
  assign mant_o    = {(exp_f != EXP_ZERO), man_f};

endmodule

// File: rtl/fp32_to_int.sv
// FP32 to int32 converter, round toward zero, with a one-bit-per-cycle shifter.
// state | meaning: IDLE wait start | SHIFT align mag | NEG apply sign | DONE pulse done
module fp32_to_int
  import fp32_to_int_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fp32_to_int_if.slave bus
);

  logic              is_nan, is_inf, is_zero;
  logic signed [8:0] exp_unb;
  logic [23:0]       mant;

  fp32_classify u_classify (
    .a_i       (bus.a),
    .is_nan_o  (is_nan),
    .is_inf_o  (is_inf),
    .is_zero_o (is_zero),
    .exp_unb_o (exp_unb),
    .mant_o    (mant)
  );

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        right_q, right_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [4:0]  shift_n;

  assign shift_n = (exp_unb < 9'sd23) ? (5'd23 - exp_unb[4:0]) : (exp_unb[4:0] - 5'd23);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      sign_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      right_q  <= right_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    right_d  = right_q;
    sign_d   = sign_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_nan || is_inf) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = DONE;
          end else if (is_zero || (exp_unb < 9'sd0)) begin
            result_d = '0;
            err_d    = 1'b0;
            state_d  = DONE;
          end else if (exp_unb >= 9'sd31) begin
            if (bus.a[31]) begin
              // Exactly -2^31 is representable; every other case saturates.
              result_d = INT_MIN;
              err_d    = !((exp_unb == 9'sd31) && (mant[22:0] == '0));
            end else begin
              result_d = INT_MAX;
              err_d    = 1'b1;
            end
            state_d = DONE;
          end else begin
            mag_d   = {8'b0, mant};
            cnt_d   = shift_n;
            right_d = (exp_unb < 9'sd23);
            sign_d  = bus.a[31];
            state_d = (shift_n == 5'd0) ? NEG : SHIFT;
          end
        end
      end
      SHIFT: begin
        mag_d = right_q ? (mag_q >> 1) : (mag_q << 1);
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = NEG;
      end
      NEG: begin
        result_d = sign_q ? (~mag_q + 32'd1) : mag_q;
        err_d    = 1'b0;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_fp32_to_int.sv
// Scoreboard bench for fp32_to_int: directed vectors push expected result, err
// and completion cycle; a monitor checks each done pulse against the queue.
module tb_fp32_to_int;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          due;
    logic [31:0] a;
  } exp_t;

  exp_t exp_q[$];

  fp32_to_int_if bus ();

  fp32_to_int dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done with result=%h err=%b, required no done", bus.result, bus.err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 4;
        if (bus.result !== e.res) begin
          failures++;
          $display("FAIL result a=%h: got %h, required %h", e.a, bus.result, e.res);
        end
        if (bus.err !== e.err) begin
          failures++;
          $display("FAIL err a=%h: got %b, required %b", e.a, bus.err, e.err);
        end
        if (cyc != e.due) begin
          failures++;
          $display("FAIL latency a=%h: done at cycle %0d, required %0d", e.a, cyc, e.due);
        end
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_in_done a=%h: got %b, required 1", e.a, bus.busy);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic push, input logic [31:0] res,
                       input logic err, input int lat);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    if (push) begin
      e.res = res; e.err = err; e.due = cyc + lat; e.a = a;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d expectation(s) pending after %0d cycles, required 0", exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  task automatic conv(input logic [31:0] a, input logic [31:0] res, input logic err, input int lat);
    issue(a, 1'b1, res, err, lat);
    drain(60);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] res;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    cyc       = 0;
    checks    = 0;
    failures  = 0;

    vecs = '{
      '{32'h3F80_0000, 32'h0000_0001, 1'b0, 25},  //  1.0, E=0
      '{32'h42F6_0000, 32'h0000_007B, 1'b0, 19},  //  123.0
      '{32'h4B80_0000, 32'h0100_0000, 1'b0,  3},  //  2^24, left by 1
      '{32'h4B00_0000, 32'h0080_0000, 1'b0,  2},  //  2^23, no shift
      '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 24},  // -2.5
      '{32'hC2F7_8000, 32'hFFFF_FF85, 1'b0, 19},  // -123.75
      '{32'hBF80_0000, 32'hFFFF_FFFF, 1'b0, 25},  // -1.0
      '{32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 25},  //  1.99999
      '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0,  9},  //  largest E=30
      '{32'h3F00_0000, 32'h0000_0000, 1'b0,  1},  //  0.5
      '{32'h0000_0000, 32'h0000_0000, 1'b0,  1},  //  +0
      '{32'h0000_0001, 32'h0000_0000, 1'b0,  1},  //  denormal
      '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1,  1},  //  2^31
      '{32'hCF00_0000, 32'h8000_0000, 1'b0,  1},  // -2^31 exact
      '{32'hCF00_0001, 32'h8000_0000, 1'b1,  1},  // just below -2^31
      '{32'hCF80_0000, 32'h8000_0000, 1'b1,  1},  // -2^32
      '{32'h7FC0_0000, 32'h0000_0000, 1'b1,  1},  //  NaN
      '{32'hFF80_0000, 32'h0000_0000, 1'b1,  1}   // -Inf
    };

    repeat (3) @(negedge clk);
    check1("reset_busy",   {31'b0, bus.busy}, 32'h0);
    check1("reset_done",   {31'b0, bus.done}, 32'h0);
    check1("reset_result", bus.result,        32'h0);
    check1("reset_err",    {31'b0, bus.err},  32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) conv(vecs[i].a, vecs[i].res, vecs[i].err, vecs[i].lat);

    // Result and err hold after completion.
    conv(32'h42F6_0000, 32'h0000_007B, 1'b0, 19);
    repeat (5) @(negedge clk);
    check1("result_hold", bus.result, 32'h0000_007B);
    check1("err_hold", {31'b0, bus.err}, 32'h0);

    // Second start while busy is dropped.
    issue(32'h3F80_0000, 1'b1, 32'h0000_0001, 1'b0, 25);
    repeat (3) @(negedge clk);
    check1("busy_mid", {31'b0, bus.busy}, 32'h1);
    issue(32'h4000_0000, 1'b0, '0, 1'b0, 0);
    drain(60);
    repeat (30) @(negedge clk);

    // Reset during SHIFT aborts the conversion with no done pulse.
    issue(32'h3F80_0000, 1'b0, '0, 1'b0, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check1("abort_busy",   {31'b0, bus.busy}, 32'h0);
    check1("abort_result", bus.result,        32'h0);
    check1("abort_err",    {31'b0, bus.err},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    conv(32'h4B80_0000, 32'h0100_0000, 1'b0, 3);

    repeat (3) @(negedge clk);
    check1("queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp32_to_int.md
# fp32_to_int

Multi-cycle converter from IEEE-754 single precision to 32-bit two's-complement signed integer, rounding toward zero. It is the unpacking counterpart of the floating-point adder: it consumes the packed sign/exponent/mantissa format that the adder produces and returns a plain integer for fixed-point consumers. The shifter is iterative (one bit per cycle), so the block trades latency for area, and NaN/Inf handling stays consistent with the adder (zero result, error flagged).

## Interface
Parameters:
- none; widths are fixed by the FP32 format.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: request; sampled only in IDLE, ignored otherwise.
- `a` in 32: FP32 operand; sampled on the edge that accepts `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse, high only in DONE.
- `result` out 32: signed integer; held until the next completion.
- `err` out 1: NaN, Inf or overflow flag, updated together with `result`.

## Operation
- Field split: s = a[31], e = a[30:23], m = a[22:0], E = e − 127 (signed).
- Classification happens on the `start` edge in IDLE:
  - e==255 (NaN or Inf): result=0, err=1, go to DONE.
  - e==0 (zero or denormal), or E<0: result=0, err=0, go to DONE.
  - E≥31: go to DONE with a saturated result.
    - If s=1 with E==31 and m==0 (exactly −2^31): result=0x8000_0000, err=0.
    - Any other negative value: result=0x8000_0000, err=1.
    - Any positive value: result=0x7FFF_FFFF, err=1.
  - Otherwise (0≤E≤30): load mag = {8'b0, 1'b1, m}, set n = |E−23| (0..23), and record the direction (right if E<23).
    - n>0: go to SHIFT.
    - n==0: go to NEG.
- SHIFT: each cycle, mag shifts one bit (logical right or left) and n decrements. When n reaches 0, go to NEG.
  - Bits shifted out on the right are discarded, which truncates toward zero.
- NEG: result = s ? −mag : mag, err=0, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- `start` in any state other than IDLE is dropped. It is not queued.

## Timing
- Reset (asynchronous) sets state=IDLE, busy=0, done=0, result=0, err=0. Reset asserted mid-conversion aborts it; no done pulse follows.
- Edge 0 is the edge that samples `start` in IDLE; busy rises after it.
- Special cases (NaN/Inf/zero/E<0/E≥31): DONE is reached at edge 0, so done is high in the first cycle after the start cycle.
- Normal cases: state sequence is SHIFT×n, then NEG, then DONE. done is high n+2 cycles after the start cycle.
  - Worst case is E=0: n=23, latency 25 cycles.
  - Best case is E=23: n=0, latency 2 cycles.
- result and err change only on the edge that enters DONE. They are stable during the done pulse and until the next conversion completes.
- busy stays high through DONE and falls on the edge that returns to IDLE. A new start is therefore accepted in the cycle right after the done pulse.
- Left shifts never overflow: E≤30 guarantees that the leading 1 lands at bit ≤30.

## Structure
- Shared package holds:
  - FP_BIAS=127, FP_EXP_W=8, FP_MANT_W=23
  - exponent constants EXP_SPECIAL=8'hFF, EXP_ZERO=8'h00
  - the state enum {IDLE, SHIFT, NEG, DONE}
  - INT_MAX=32'h7FFF_FFFF, INT_MIN=32'h8000_0000

  The adder and future FP blocks reuse the same package.
- One sub-module is natural: `fp32_classify`. It is combinational: it takes `a` and outputs is_nan, is_inf, is_zero, unbiased E, and the hidden-bit mantissa. The same classifier can replace the inline checks in the adder.
- The FSM, the 5-bit counter, the 32-bit mag shifter and the output registers all stay in fp32_to_int.

## Test plan
- a=0x3F80_0000 (1.0) → result=1, err=0, done 25 cycles after start (n=23).
- a=0x42F6_0000 (123.0) → result=0x0000_007B; a=0x4B80_0000 (2^24) → result=0x0100_0000, latency 3 cycles.
- a=0xC020_0000 (−2.5) → result=0xFFFF_FFFE (−2); a=0x3F00_0000 (0.5) → result=0, err=0, latency 1 cycle.
- a=0x4F00_0000 (2^31) → result=0x7FFF_FFFF, err=1; a=0xCF00_0000 → result=0x8000_0000, err=0; a=0x7FC0_0000 (NaN) → result=0, err=1, latency 1 cycle.
- Pulse start with 0x3F80_0000, then pulse start with 0x4000_0000 while busy → exactly one done, result=1; the second request is ignored.
- Assert rst_n low during SHIFT → outputs go to 0 immediately, no done pulse; the next start converts normally.
